cache_refill_assembler: RTL and testbench
=========================================

Name: cache_refill_assembler

Overview:
- Inverse of word extraction from a cache line: collects a wrapping burst of word-wide refill beats from the memory side and assembles them into one full cache line.
- The finished line is handed to the cache data SRAM write path.
- Sits between the cache miss FSM and the bus read channel; one refill is in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of one refill beat / cache word.
- Cache_line_size, 512, line width in bits; must be a power-of-2 multiple of DATA_WIDTH.
- Addr_len (localparam), $clog2(Cache_line_size/DATA_WIDTH), word-offset width (4 at defaults).
- BEATS (localparam), Cache_line_size/DATA_WIDTH, beats per line (16 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss FSM requests a refill.
- req_ready  out  1  assembler can accept a request.
- req_offset  in  Addr_len  critical word offset; first beat lands here.
- beat_valid  in  1  refill beat present.
- beat_ready  out  1  assembler accepts the beat.
- beat_data  in  DATA_WIDTH  refill word.
- beat_last  in  1  bus marks the final beat.
- line_valid  out  1  assembled line available.
- line_ready  in  1  consumer takes the line.
- line_data  out  Cache_line_size  assembled line; word k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- len_err  out  1  one-cycle pulse on a beat_last/count mismatch.
- crit_valid  out  1  critical-word forward strobe (optional feature).
- crit_data  out  DATA_WIDTH  critical word (optional feature).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, cnt=0, start=0, line_data=0.
  - req_ready=1 (IDLE); beat_ready, line_valid, len_err, crit_valid = 0; crit_data=0.
  - Reset mid-FILL or mid-DONE discards the partial or complete line. No line_valid follows until a new request completes.
- State IDLE:
  - req_ready=1, beat_ready=0.
  - Handshake req_valid&req_ready: start<=req_offset, cnt<=0, go to FILL.
  - line_data is not cleared on request; stale words are overwritten beat by beat.
- State FILL:
  - beat_ready=1, req_ready=0.
  - Accepted beat (beat_valid&beat_ready): word index = (start+cnt) mod BEATS, using Addr_len-bit wrap-around arithmetic; that word of line_data <= beat_data; cnt<=cnt+1.
  - Accept on cnt==BEATS-1: go to DONE.
  - The transfer always terminates by count, never by beat_last.
  - Any accepted beat where beat_last != (cnt==BEATS-1): len_err=1 on the next cycle, for exactly one cycle. Beats after an early beat_last still fill the line.
  - beat_valid low: hold state, no write. Gaps of any length are legal.
- State DONE:
  - line_valid=1, line_data stable, beat_ready=0, req_ready=0.
  - line_ready=1: go to IDLE; line_valid drops the next cycle.
  - req_valid together with line_ready is not accepted in that cycle; it is accepted the following cycle in IDLE.
- Latency:
  - Last beat accepted in cycle N: line_valid=1 in cycle N+1.
  - Minimum request-to-line time: 1 + BEATS cycles.
  - Back-to-back refills: one idle cycle between line handoff and the next request.
- Beats presented in IDLE or DONE are not accepted (beat_ready=0); they cause no state change.

Optional Feature:
- Macro: CRIT_WORD_FWD_EN.
- Defined:
  - In the cycle after the first beat of a refill is accepted (cnt==0), crit_valid=1 for exactly one cycle.
  - crit_data holds that beat's data and is held until the next critical beat.
  - This lets the pipeline restart before the line completes.
- Undefined: crit_valid and crit_data are tied to 0; no extra registers.

Test Plan:
- Aligned refill: req_offset=0, 16 back-to-back beats 0x1000+k, beat_last on the 16th -> line_valid in the cycle after the 16th accept; word k = 0x1000+k; len_err never pulses.
- Wrapped refill: req_offset=0xD, beats 0xA0..0xAF -> word 0xD=0xA0, word 0xF=0xA2, word 0x0=0xA3, word 0xC=0xAF.
- Gapped beats with line_ready held low: beat_valid toggled 1/0, line_ready=0 for 5 cycles after completion -> 16 writes only; line_valid and line_data held stable; req_ready=0 until handoff; a new req accepted 1 cycle after line_ready.
- Length error: beat_last asserted on beat 10 (cnt=9) and not on beat 16 -> len_err pulses twice, one cycle each; line still completes after 16 beats.
- Reset after 7 beats of a refill -> all outputs return to reset values immediately; a following fresh refill with offset 3 produces a correct line with no stale-count effects.
- CRIT_WORD_FWD_EN defined, req_offset=5, first beat 0xDEADBEEF -> crit_valid=1 for one cycle after the first accept with crit_data=0xDEADBEEF. With the macro undefined, crit_valid stays 0.

Source files
------------

// File: rtl/cache_refill_assembler.sv
//------------------------------------------------------------------------------
// cache_refill_assembler
//
// Collects a wrapping burst of word-wide refill beats from the bus read
// channel and assembles them into one full cache line for the data SRAM
// write path. One refill is in flight at a time.
//
// Optional feature macro: CRIT_WORD_FWD_EN
//   defined   -> crit_valid/crit_data forward the first (critical) beat of
//                each refill one cycle after it is accepted.
//   undefined -> crit_valid and crit_data are tied to zero.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req_valid   refill request from the miss FSM
//   req_ready   assembler idle, request can be taken
//   req_offset  critical word offset; first beat lands in this word
//   beat_valid  refill beat present on the bus
//   beat_ready  assembler accepts the beat
//   beat_data   refill word
//   beat_last   bus marks the final beat (checked, not used to terminate)
//   line_valid  assembled line available
//   line_ready  consumer takes the line
//   line_data   assembled line, word k at [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
//   len_err     one-cycle pulse on a beat_last / beat count mismatch
//   crit_valid  critical-word forward strobe
//   crit_data   critical word
//------------------------------------------------------------------------------
module cache_refill_assembler #(
   parameter int DATA_WIDTH      = 32,
   parameter int Cache_line_size = 512
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               req_valid,
   output logic                                               req_ready,
   input  logic [$clog2(Cache_line_size/DATA_WIDTH)-1:0]      req_offset,
   input  logic                                               beat_valid,
   output logic                                               beat_ready,
   input  logic [DATA_WIDTH-1:0]                              beat_data,
   input  logic                                               beat_last,
   output logic                                               line_valid,
   input  logic                                               line_ready,
   output logic [Cache_line_size-1:0]                         line_data,
   output logic                                               len_err,
   output logic                                               crit_valid,
   output logic [DATA_WIDTH-1:0]                              crit_data
);

   localparam int BEATS    = Cache_line_size / DATA_WIDTH;
   localparam int Addr_len = $clog2(BEATS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [Addr_len-1:0] LAST_CNT = Addr_len'(BEATS - 1);

   logic [1:0]          state;
   logic [Addr_len-1:0] cnt;
   logic [Addr_len-1:0] start;
   logic [Addr_len-1:0] wr_idx;
   logic                beat_acc;
   logic                last_beat;

   assign req_ready  = (state == IDLE);
   assign beat_ready = (state == FILL);
   assign line_valid = (state == DONE);

   assign beat_acc  = beat_valid & beat_ready;
   assign last_beat = (cnt == LAST_CNT);
   // Addr_len-bit sum wraps naturally modulo BEATS.
   assign wr_idx    = start + cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         start     <= '0;
         line_data <= '0;
         len_err   <= 1'b0;
      end else begin
         len_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  start <= req_offset;
                  cnt   <= '0;
                  state <= FILL;
               end
            end
            FILL: begin
               if (beat_valid) begin
                  for (int unsigned k = 0; k < BEATS; k++) begin
                     if (wr_idx == Addr_len'(k))
                        line_data[k*DATA_WIDTH +: DATA_WIDTH] <= beat_data;
                  end
                  cnt     <= cnt + 1'b1;
                  // Termination is by count; beat_last only flags errors.
                  len_err <= (beat_last != last_beat);
                  if (last_beat)
                     state <= DONE;
               end
            end
            DONE: begin
               if (line_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CRIT_WORD_FWD_EN
   logic                  crit_valid_q;
   logic [DATA_WIDTH-1:0] crit_data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
      end else begin
         crit_valid_q <= beat_acc && (cnt == '0);
         if (beat_acc && (cnt == '0))
            crit_data_q <= beat_data;
      end
   end

   assign crit_valid = crit_valid_q;
   assign crit_data  = crit_data_q;
`else
   logic unused_acc;
   assign unused_acc = beat_acc;
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_assembler.sv
module tb_cache_refill_assembler;

   localparam int DW = 32;
   localparam int LS = 512;
   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_offset;
   logic          beat_valid;
   logic          beat_ready;
   logic [DW-1:0] beat_data;
   logic          beat_last;
   logic          line_valid;
   logic          line_ready;
   logic [LS-1:0] line_data;
   logic          len_err;
   logic          crit_valid;
   logic [DW-1:0] crit_data;

   cache_refill_assembler #(.DATA_WIDTH(DW), .Cache_line_size(LS)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_offset (req_offset),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .beat_data  (beat_data),
      .beat_last  (beat_last),
      .line_valid (line_valid),
      .line_ready (line_ready),
      .line_data  (line_data),
      .len_err    (len_err),
      .crit_valid (crit_valid),
      .crit_data  (crit_data)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int len_err_seen = 0;
   int crit_seen    = 0;
   logic [DW-1:0] crit_last = '0;
   logic [LS-1:0] exp_q[$];

`ifdef CRIT_WORD_FWD_EN
   localparam int CRIT_PER_REFILL = 1;
`else
   localparam int CRIT_PER_REFILL = 0;
`endif

   task automatic chk(input string nm, input logic [LS-1:0] act, input logic [LS-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Scoreboard monitor: every line handoff pops one expected line.
   always @(negedge clk) begin
      if (!reset && line_valid && line_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_line", 1, 0);
         end else begin
            chk("line_data", line_data, exp_q.pop_front());
         end
      end
      if (len_err) len_err_seen++;
      if (crit_valid) begin
         crit_seen++;
         crit_last = crit_data;
      end
   end

   task automatic do_req(input logic [3:0] off);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!req_ready) chk("req_ready_timeout", 0, 1);
      req_valid  = 1'b1;
      req_offset = off;
      @(posedge clk); #1;
      req_valid  = 1'b0;
   endtask

   // Sends 16 beats base+k (beat 0 replaced by first), beat_last on beat
   // index last_at, gap idle cycles between beats. Pushes the expected line.
   task automatic send_beats(input logic [3:0] off, input logic [DW-1:0] base,
                             input logic [DW-1:0] first, input int last_at,
                             input int gap, output logic [LS-1:0] expl);
      logic [3:0] idx;
      expl = '0;
      for (int k = 0; k < NB; k++) begin
         idx = off + 4'(k);
         expl[int'(idx)*DW +: DW] = (k == 0) ? first : base + DW'(k);
      end
      exp_q.push_back(expl);
      for (int k = 0; k < NB; k++) begin
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               beat_valid = 1'b0;
               beat_data  = 32'hBAD0_0000 + DW'(g);
               @(posedge clk); #1;
            end
         end
         beat_valid = 1'b1;
         beat_data  = (k == 0) ? first : base + DW'(k);
         beat_last  = (k == last_at);
         @(posedge clk); #1;
      end
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      chk("line_valid_latency", LS'(line_valid), LS'(1));
   endtask

   logic [LS-1:0] expl;
   int le0, cr0;

   initial begin
      reset = 1'b1; req_valid = 0; req_offset = '0; beat_valid = 0;
      beat_data = '0; beat_last = 0; line_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready",  LS'(req_ready),  LS'(1));
      chk("rst_beat_ready", LS'(beat_ready), LS'(0));
      chk("rst_line_valid", LS'(line_valid), LS'(0));
      chk("rst_line_data",  line_data,       LS'(0));
      chk("rst_len_err",    LS'(len_err),    LS'(0));
      chk("rst_crit",       LS'({crit_valid, crit_data}), LS'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      // Beat offered in IDLE must be ignored.
      beat_valid = 1'b1; beat_data = 32'h5555_5555;
      @(posedge clk); #1;
      chk("idle_beat_ignored", LS'(beat_ready), LS'(0));
      beat_valid = 1'b0;

      // Aligned refill
      le0 = len_err_seen; cr0 = crit_seen;
      do_req(4'h0);
      send_beats(4'h0, 32'h1000, 32'h1000, 15, 0, expl);
      chk("aligned_word0", LS'(line_data[0 +: DW]), LS'(32'h1000));
      chk("aligned_word15", LS'(line_data[15*DW +: DW]), LS'(32'h100F));
      @(posedge clk); #1;
      chk("aligned_len_err", LS'(len_err_seen - le0), LS'(0));
      chk("aligned_crit_cnt", LS'(crit_seen - cr0), LS'(CRIT_PER_REFILL));

      // Wrapped refill
      do_req(4'hD);
      send_beats(4'hD, 32'hA0, 32'hA0, 15, 0, expl);
      chk("wrap_word_D", LS'(line_data[13*DW +: DW]), LS'(32'hA0));
      chk("wrap_word_F", LS'(line_data[15*DW +: DW]), LS'(32'hA2));
      chk("wrap_word_0", LS'(line_data[0 +: DW]),     LS'(32'hA3));
      chk("wrap_word_C", LS'(line_data[12*DW +: DW]), LS'(32'hAF));
      @(posedge clk); #1;

      // Gapped beats, line held by consumer
      line_ready = 1'b0;
      do_req(4'h6);
      send_beats(4'h6, 32'h600, 32'h600, 15, 1, expl);
      for (int c = 0; c < 5; c++) begin
         beat_valid = 1'b1; beat_data = 32'hFFFF_0000 + DW'(c);
         req_valid = 1'b1; req_offset = 4'h1;
         @(posedge clk); #1;
         chk("hold_line_valid", LS'(line_valid), LS'(1));
         chk("hold_line_data",  line_data,       expl);
         chk("hold_req_ready",  LS'(req_ready),  LS'(0));
      end
      beat_valid = 1'b0;
      // Handoff with a simultaneous request: taken only the cycle after.
      line_ready = 1'b1; req_valid = 1'b1; req_offset = 4'h2;
      @(posedge clk); #1;
      chk("handoff_idle", LS'(req_ready), LS'(1));
      chk("handoff_no_line", LS'(line_valid), LS'(0));
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("req_taken_next", LS'(beat_ready), LS'(1));

      // Length error: beat_last on beat 10, absent on beat 16
      le0 = len_err_seen;
      send_beats(4'h2, 32'h200, 32'h200, 9, 0, expl);
      @(posedge clk); #1;
      chk("len_err_pulses", LS'(len_err_seen - le0), LS'(2));

      // Reset mid-refill after 7 beats
      do_req(4'h9);
      for (int k = 0; k < 7; k++) begin
         beat_valid = 1'b1; beat_data = 32'h7700 + DW'(k);
         @(posedge clk); #1;
      end
      beat_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_req_ready",  LS'(req_ready),  LS'(1));
      chk("midrst_beat_ready", LS'(beat_ready), LS'(0));
      chk("midrst_line_valid", LS'(line_valid), LS'(0));
      chk("midrst_line_data",  line_data,       LS'(0));
      chk("midrst_crit",       LS'({crit_valid, crit_data}), LS'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      do_req(4'h3);
      send_beats(4'h3, 32'h300, 32'h300, 15, 0, expl);
      chk("post_rst_word3", LS'(line_data[3*DW +: DW]), LS'(32'h300));
      chk("post_rst_word2", LS'(line_data[2*DW +: DW]), LS'(32'h30F));
      @(posedge clk); #1;

      // Critical word forward
      cr0 = crit_seen;
      do_req(4'h5);
      beat_valid = 1'b1; beat_data = 32'hDEADBEEF; beat_last = 1'b0;
      @(posedge clk); #1;
      beat_valid = 1'b0;
      chk("crit_valid_strobe", LS'(crit_valid), LS'(CRIT_PER_REFILL));
`ifdef CRIT_WORD_FWD_EN
      chk("crit_data", LS'(crit_data), LS'(32'hDEADBEEF));
`else
      chk("crit_data_tied", LS'(crit_data), LS'(0));
`endif
      @(posedge clk); #1;
      chk("crit_one_cycle", LS'(crit_valid), LS'(0));
      // Remaining 15 beats complete the line (word 5 = DEADBEEF).
      begin
         logic [3:0] idx;
         expl = '0;
         expl[5*DW +: DW] = 32'hDEADBEEF;
         for (int k = 1; k < NB; k++) begin
            idx = 4'h5 + 4'(k);
            expl[int'(idx)*DW +: DW] = 32'h500 + DW'(k);
         end
         exp_q.push_back(expl);
         for (int k = 1; k < NB; k++) begin
            beat_valid = 1'b1; beat_data = 32'h500 + DW'(k); beat_last = (k == 15);
            @(posedge clk); #1;
         end
         beat_valid = 1'b0; beat_last = 1'b0;
      end
      chk("crit_line_valid", LS'(line_valid), LS'(1));
      @(posedge clk); #1;
      chk("crit_total", LS'(crit_seen - cr0), LS'(CRIT_PER_REFILL));
`ifdef CRIT_WORD_FWD_EN
      chk("crit_held", LS'(crit_data), LS'(32'hDEADBEEF));
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", LS'(exp_q.size()), LS'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
